gen_bus_mem_arbiter: RTL

Two-to-one arbiter that merges the core's instruction-fetch and data generic-bus request ports into a single memory-side generic bus. It sits directly downstream of the memory-less core top level, consuming its `igen_bus_if` and `dgen_bus_if` traffic and driving one memory or interconnect port. Each transaction is latched at grant time and held stable on the memory side until the memory deasserts `busy`. Completion is then routed back to the owning requester.

---
 rtl/gen_bus_mem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/gen_bus_mem_arbiter.sv
// Two-to-one generic-bus arbiter: merges instruction-fetch and data requests onto one memory port.
// Optional round-robin tie-breaking is enabled with `define GEN_BUS_ARB_RR_EN (fixed data priority otherwise).
module gen_bus_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic                i_ren,
  input  logic                i_wen,
  input  logic [DATA_W/8-1:0] i_byte_en,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_busy,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic                d_ren,
  input  logic                d_wen,
  input  logic [DATA_W/8-1:0] d_byte_en,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_busy,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic                m_ren,
  output logic                m_wen,
  output logic [DATA_W/8-1:0] m_byte_en,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_busy
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [BE_W-1:0]   req_byte_en_q;
  logic              req_ren_q;
  logic              req_wen_q;

  logic i_pend;
  logic d_pend;
  logic tie_to_d;
  logic pick_d;
  logic pick_i;
  logic i_done;
  logic d_done;

  assign i_pend = i_ren | i_wen;
  assign d_pend = d_ren | d_wen;

`ifdef GEN_BUS_ARB_RR_EN
  // last_grant: 0 = instruction side, 1 = data side; ties go to the other side.
  logic last_grant;

  assign tie_to_d = ~last_grant;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_grant <= 1'b0;
    end else if (state == IDLE) begin
      if (pick_d) begin
        last_grant <= 1'b1;
      end else if (pick_i) begin
        last_grant <= 1'b0;
      end
    end
  end
`else
  assign tie_to_d = 1'b1;
`endif

  assign pick_d = d_pend & (~i_pend | tie_to_d);
  assign pick_i = i_pend & ~pick_d;

  // Completion is the cycle the memory drops busy while a grant is held.
  assign i_done = (state == GRANT_I) & ~m_busy;
  assign d_done = (state == GRANT_D) & ~m_busy;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= IDLE;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      req_byte_en_q <= '0;
      req_ren_q     <= 1'b0;
      req_wen_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state         <= GRANT_D;
            req_addr_q    <= d_addr;
            req_wdata_q   <= d_wdata;
            req_byte_en_q <= d_byte_en;
            req_ren_q     <= d_ren & ~d_wen;
            req_wen_q     <= d_wen;
          end else if (pick_i) begin
            state         <= GRANT_I;
            req_addr_q    <= i_addr;
            req_wdata_q   <= i_wdata;
            req_byte_en_q <= i_byte_en;
            req_ren_q     <= i_ren & ~i_wen;
            req_wen_q     <= i_wen;
          end
        end
        GRANT_I, GRANT_D: begin
          if (!m_busy) begin
            state     <= IDLE;
            req_ren_q <= 1'b0;
            req_wen_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ren_q <= 1'b0;
          req_wen_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory side is driven purely from the latched request.
  assign m_addr    = req_addr_q;
  assign m_wdata   = req_wdata_q;
  assign m_byte_en = req_byte_en_q;
  assign m_ren     = req_ren_q;
  assign m_wen     = req_wen_q;

  assign i_busy  = ~i_done;
  assign d_busy  = ~d_done;
  assign i_rdata = i_done ? m_rdata : '0;
  assign d_rdata = d_done ? m_rdata : '0;

endmodule
